// File: rtl/jt6295_romarb.sv
// ROM arbiter for JT6295-class sample fetch: SLOTS requesters share one ROM port,
// each slot keeping a one-entry address/data cache so repeated reads hit at zero latency.
module jt6295_romarb #(
    parameter int SLOTS = 4,
    parameter int AW    = 18,
    parameter int DW    = 8,
    parameter int RR    = 0
) (
    input  logic                  rst,
    input  logic                  clk,
    input  logic [SLOTS-1:0]      slot_cs,
    input  logic [SLOTS*AW-1:0]   slot_addr,
    output logic [SLOTS*DW-1:0]   slot_dout,
    output logic [SLOTS-1:0]      slot_ok,
    output logic [AW-1:0]         rom_addr,
    output logic                  rom_cs,
    input  logic [DW-1:0]         rom_data,
    input  logic                  rom_ok
);

    // state     | meaning
    // ST_IDLE   | no fetch in flight; grant a pending slot and latch its address
    // ST_SETTLE | first cycle of a fetch; rom_ok may still refer to the old address
    // ST_WAIT   | hold the ROM request until rom_ok, then fill the granted slot
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_WAIT} state_t;

    localparam int GW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    state_t          state_q, state_d;
    logic [AW-1:0]   rom_addr_q, rom_addr_d;
    logic            rom_cs_q, rom_cs_d;
    logic [GW-1:0]   g_q, g_d;
    logic [GW-1:0]   last_q, last_d;
    logic [AW-1:0]   caddr_q [SLOTS];
    logic [AW-1:0]   caddr_d [SLOTS];
    logic [DW-1:0]   cdata_q [SLOTS];
    logic [DW-1:0]   cdata_d [SLOTS];
    logic [SLOTS-1:0] cvalid_q, cvalid_d;

    logic [SLOTS-1:0] pending;
    logic             gnt_any;
    logic [GW-1:0]    gnt_idx;
    int               rr_idx;

    always_comb begin
        slot_ok   = '0;
        pending   = '0;
        slot_dout = '0;
        for (int i = 0; i < SLOTS; i++) begin
            slot_ok[i] = slot_cs[i] & cvalid_q[i] & (caddr_q[i] == slot_addr[i*AW +: AW]);
            pending[i] = slot_cs[i] & ~slot_ok[i];
            slot_dout[i*DW +: DW] = cdata_q[i];
        end
    end

    // Both searches scan from the lowest priority up so the last match wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        rr_idx  = 0;
        if (RR == 0) begin
            for (int i = SLOTS - 1; i >= 0; i--) begin
                if (pending[GW'(i)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = GW'(i);
                end
            end
        end else begin
            for (int k = SLOTS; k >= 1; k--) begin
                rr_idx = int'(last_q) + k;
                if (rr_idx >= SLOTS) rr_idx = rr_idx - SLOTS;
                if (pending[GW'(rr_idx)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = GW'(rr_idx);
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        rom_cs_d   = rom_cs_q;
        g_d        = g_q;
        last_d     = last_q;
        caddr_d    = caddr_q;
        cdata_d    = cdata_q;
        cvalid_d   = cvalid_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    rom_addr_d = slot_addr[int'(gnt_idx)*AW +: AW];
                    rom_cs_d   = 1'b1;
                    g_d        = gnt_idx;
                    last_d     = gnt_idx;
                    state_d    = ST_SETTLE;
                end else begin
                    rom_cs_d   = 1'b0;
                end
            end
            ST_SETTLE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (rom_ok) begin
                    cdata_d[g_q]  = rom_data;
                    caddr_d[g_q]  = rom_addr_q;
                    cvalid_d[g_q] = 1'b1;
                    rom_cs_d      = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= '0;
            rom_cs_q   <= 1'b0;
            g_q        <= '0;
            last_q     <= GW'(SLOTS - 1);
            cvalid_q   <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                caddr_q[i] <= '0;
                cdata_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            rom_cs_q   <= rom_cs_d;
            g_q        <= g_d;
            last_q     <= last_d;
            cvalid_q   <= cvalid_d;
            caddr_q    <= caddr_d;
            cdata_q    <= cdata_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign rom_cs   = rom_cs_q;

endmodule

// File: doc/jt6295_romarb.md
# jt6295_romarb

Parametrised ROM arbiter for JT6295-class sample fetch. Shares one external ROM port (SDRAM-style `rom_ok` handshake) among `SLOTS` requesters. Each slot has a one-entry address/data cache, so repeated reads of the same address hit without touching the ROM. Arbitration is fixed-priority (slot 0 highest) or round-robin, chosen at elaboration; it sits between the ADPCM/header fetch logic and the top-level ROM interface.

## Interface
- `SLOTS`, 4: number of requesting slots, 2..8.
- `AW`, 18: address width.
- `DW`, 8: data width.
- `RR`, 0: arbitration mode. 0 = fixed priority, lowest index wins. 1 = round-robin.

- `rst`  in  1  synchronous, active-high reset
- `clk`  in  1  single clock; all state changes on rising edge
- `slot_cs`  in  SLOTS  per-slot read request, level
- `slot_addr`  in  SLOTS*AW  slot i at `[i*AW +: AW]`
- `slot_dout`  out  SLOTS*DW  slot i cached data at `[i*DW +: DW]`, registered
- `slot_ok`  out  SLOTS  slot i data valid for its current address, combinational
- `rom_addr`  out  AW  ROM address, registered
- `rom_cs`  out  1  ROM request, registered
- `rom_data`  in  DW  ROM data
- `rom_ok`  in  1  ROM data valid for `rom_addr`

## Operation
- Per-slot state: `caddr[i]` (AW), `cdata[i]` (DW, drives `slot_dout`), `cvalid[i]`.
- Hit: `slot_ok[i] = slot_cs[i] & cvalid[i] & (caddr[i]==slot_addr[i])`.
- Pending: `slot_cs[i] & ~slot_ok[i]`.
- FSM states: IDLE, SETTLE, WAIT.
  - IDLE: if any slot is pending, grant one (index `g`). Latch `rom_addr<=slot_addr[g]` and `rom_cs<=1`, then go to SETTLE. Otherwise stay in IDLE with `rom_cs=0`.
  - SETTLE: one cycle. `rom_ok` is ignored here because it may be stale from the previous address. Go to WAIT.
  - WAIT: hold `rom_addr` and `rom_cs`. When `rom_ok=1`:
    - `cdata[g]<=rom_data`, `caddr[g]<=rom_addr`, `cvalid[g]<=1`.
    - `rom_cs<=0`, go to IDLE.
  - No timeout.
- Grant, RR=0: lowest pending index.
- Grant, RR=1: first pending index searched circularly from `last+1`. `last` updates to `g` at grant time and wraps `SLOTS-1 -> 0`.
- Slot changes `slot_addr` or drops `slot_cs` mid-fetch: the fetch still completes and fills the cache with the latched address. If the slot's address now differs, `slot_ok` stays 0 and the slot becomes pending again at the next IDLE.
- Non-granted slots keep their cache untouched. A hit on one slot never waits on another slot's fetch.
- Two slots requesting the same address: each fetches separately; there is no cross-slot sharing.

## Timing
- Reset values: `rom_cs=0`, `rom_addr=0`, `slot_dout=0`, all `cvalid=0` (so `slot_ok=0`), state IDLE, RR `last=SLOTS-1` so slot 0 is searched first.
- Reset asserted mid-fetch: everything returns to reset values on the next edge. A `rom_ok` arriving in that cycle is discarded.
- Hit latency: 0 cycles. `slot_ok` and `slot_dout` are valid in the same cycle `slot_cs` and the address are presented.
- Miss latency, with the miss seen in IDLE at edge n:
  - `rom_cs=1` and `rom_addr` valid after edge n+1 (SETTLE).
  - Earliest `rom_ok` sample is at edge n+2 (WAIT).
  - `slot_ok` and `slot_dout` valid after edge n+3.
  - Each extra `rom_ok=0` cycle in WAIT adds one cycle.
- Back-to-back: the next grant is evaluated in the IDLE cycle after a fill, giving a minimum of 3 cycles per ROM access.
- `rom_addr` is stable from SETTLE through the `rom_ok` cycle inclusive.

## Test plan
- Reset, then idle: `rom_cs=0`, `slot_ok=0` for every slot, `slot_dout=0`.
- Single miss, SLOTS=4, slot 2 requests `0x01234`, `rom_ok` in the first WAIT cycle with data `0xA5`: `rom_addr=0x01234` for 2 cycles, `slot_ok[2]=1` and `slot_dout[2]=0xA5` three cycles after the request. Re-requesting the same address gives a hit the same cycle with no `rom_cs`.
- RR=0, slots 0 and 3 miss together: slot 0 is fetched first, then slot 3. With RR=1 and `last=0`, slots 0, 1 and 3 pending are granted in the order 1, 3, 0.
- Stale `rom_ok`: `rom_ok` held at 1 during SETTLE, data `0x11`, then data `0x22` in WAIT: the cache stores `0x22`.
- Slot 1 changes address from `0x00010` to `0x00020` during WAIT: the fill stores `0x00010`, `slot_ok[1]` stays 0, and a second fetch of `0x00020` follows.
- `rst` pulsed during WAIT with `rom_ok=1`: `cvalid` is cleared, `rom_cs=0` the next cycle, and no slot reports ok.
